mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit for the MEM stage of the 5-stage MIPS pipeline, sitting directly upstream of the word-addressed data memory. It converts LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses, extracts and extends sub-word load data, and performs byte/halfword stores as a two-cycle read-modify-write with a pipeline stall request. It also detects misaligned accesses and latches the faulting address for the exception logic.

## Interface
- DATA_W, 32, data and address width (matches `RegBus`/`DataAddrBus`)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- mem_addr  in  32  effective byte address from EX/MEM
- mem_sdata  in  32  store source register value
- flush  in  1  pipeline flush; kills current/pending access
- dm_ce  out  1  data memory chip enable
- dm_we  out  1  data memory write enable
- dm_addr  out  32  byte address to data memory (bits [1:0] always 0)
- dm_wdata  out  32  word to write
- dm_rdata  in  32  combinational read word from data memory
- load_data  out  32  extended load result to MEM/WB
- stall_req  out  1  hold IF..MEM for one cycle
- addr_err  out  1  misaligned access this cycle
- bad_addr  out  32  last misaligned address (sticky)

## Operation
- Memory is big-endian: byte offset 0 = bits [31:24], 3 = bits [7:0]; halfword offset 0 = [31:16], 2 = [15:0].
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. Then addr_err=1, dm_ce=0, stall_req=0, load_data=0, bad_addr ← mem_addr at clock edge. Not raised while flush=1.
- FSM states IDLE, RMW.
- IDLE, op none or flush=1: dm_ce=0, dm_we=0, dm_addr=0, dm_wdata=0, load_data=0.
- IDLE, aligned load: dm_ce=1, dm_we=0, dm_addr={addr[31:2],2'b00}; load_data = selected byte/half sign-extended (LB/LH) or zero-extended (LBU/LHU), full word for LW. Stay IDLE.
- IDLE, aligned SW: dm_ce=1, dm_we=1, dm_wdata=mem_sdata. Stay IDLE, no stall.
- IDLE, aligned SB/SH: dm_ce=1, dm_we=0 (read), stall_req=1; at edge capture rmw_addr (word-aligned) and rmw_word = dm_rdata with the addressed lane replaced by mem_sdata[7:0]/[15:0]; go RMW.
- RMW: dm_ce=1, dm_we=1, dm_addr=rmw_addr, dm_wdata=rmw_word, stall_req=0, load_data=0; inputs ignored; next IDLE. If flush=1 in RMW: dm_ce=0, dm_we=0, write dropped, next IDLE.
- Inputs are re-presented by the stalled pipeline in the RMW cycle but are not used; the instruction after the store is processed in the cycle following RMW.

## Timing
- Reset values: state IDLE, rmw_addr 0, rmw_word 0, bad_addr 0; all outputs 0.
- Reset assertion mid-RMW: immediate return to IDLE, dm_we drops asynchronously, write not performed.
- Loads and SW: 0-cycle latency (combinational through dm_rdata), 1 pipeline cycle.
- SB/SH: 2 cycles; stall_req high exactly during the read cycle; memory updated at the end of the RMW cycle.
- Back-to-back SB to same word: second read occurs after first write commits, sees merged data.
- All outputs are combinational from state, registers and inputs; no output registers.

## Test plan
- Reset then word 0x00000010 preloaded 0x11223344; LB/LBU/LH/LHU/LW at 0x10–0x13 -> LB@0x13=0x00000044, LB@0x10 with 0x81223344 =0xFFFFFF81, LBU=0x00000081, LH@0x12=0x00003344, LW=0x11223344.
- SB 0xAA to 0x11 over word 0x11223344 -> stall_req high 1 cycle, then dm_we=1, dm_wdata=0x11AA3344; following LW returns 0x11AA3344.
- SH 0xBEEF to 0x12 then SB 0x55 to 0x10 back-to-back -> word 0x5522BEEF; total 4 cycles, two stall pulses.
- LW at 0x22, SH at 0x13 -> addr_err=1, dm_ce=0, no stall; bad_addr=0x22 then 0x13; memory unchanged.
- SB issued, flush=1 during RMW cycle -> no write, word unchanged; rst pulled low during RMW -> no write, all outputs 0, state IDLE.
- SW 0xDEADBEEF to 0x04 -> single cycle write, stall_req stays 0, LW returns 0xDEADBEEF.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Data memory bus between the load/store unit and the word-addressed RAM.
// The LSU drives the request side; the memory returns a combinational read word.
interface mem_lsu_if #(
  parameter int DATA_W = 32
);
  logic              dm_ce;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_ce,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_rdata
  );

  modport slave (
    input  dm_ce,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: sub-word loads and stores on big-endian word memory.
// Byte and halfword stores take two cycles: read with a stall, then write.
module mem_lsu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mem_op,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_sdata,
  input  logic              flush,
  mem_lsu_if.master         dm,
  output logic [DATA_W-1:0] load_data,
  output logic              stall_req,
  output logic              addr_err,
  output logic [DATA_W-1:0] bad_addr
);

  typedef enum logic {IDLE, RMW} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [DATA_W-1:0] rmw_word_q, rmw_word_d;
  logic [DATA_W-1:0] bad_addr_q, bad_addr_d;

  logic              is_ld, is_sw, is_sub, mis;
  logic [DATA_W-1:0] waddr, ld_val, merged;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  assign waddr  = {mem_addr[DATA_W-1:2], 2'b00};
  assign is_ld  = (mem_op >= 4'd1) && (mem_op <= 4'd5);
  assign is_sw  = (mem_op == 4'd8);
  assign is_sub = (mem_op == 4'd6) || (mem_op == 4'd7);
  assign mis    = ((mem_op == 4'd3 || mem_op == 4'd4 || mem_op == 4'd7)
                   && mem_addr[0])
               || ((mem_op == 4'd5 || mem_op == 4'd8)
                   && (mem_addr[1:0] != 2'b00));
  assign bad_addr = bad_addr_q;

  // Lane 0 is the most significant byte (big-endian).
  always_comb begin
    rbyte = 8'h00;
    unique case (mem_addr[1:0])
      2'd0: rbyte = dm.dm_rdata[31:24];
      2'd1: rbyte = dm.dm_rdata[23:16];
      2'd2: rbyte = dm.dm_rdata[15:8];
      2'd3: rbyte = dm.dm_rdata[7:0];
    endcase
    rhalf = mem_addr[1] ? dm.dm_rdata[15:0] : dm.dm_rdata[31:16];
  end

  always_comb begin
    ld_val = '0;
    unique case (mem_op)
      4'd1:    ld_val = {{24{rbyte[7]}}, rbyte};
      4'd2:    ld_val = {24'h0, rbyte};
      4'd3:    ld_val = {{16{rhalf[15]}}, rhalf};
      4'd4:    ld_val = {16'h0, rhalf};
      4'd5:    ld_val = dm.dm_rdata;
      default: ld_val = '0;
    endcase
  end

  always_comb begin
    merged = dm.dm_rdata;
    if (mem_op == 4'd6) begin
      unique case (mem_addr[1:0])
        2'd0: merged[31:24] = mem_sdata[7:0];
        2'd1: merged[23:16] = mem_sdata[7:0];
        2'd2: merged[15:8]  = mem_sdata[7:0];
        2'd3: merged[7:0]   = mem_sdata[7:0];
      endcase
    end else if (mem_addr[1]) begin
      merged[15:0] = mem_sdata[15:0];
    end else begin
      merged[31:16] = mem_sdata[15:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_word_d  = rmw_word_q;
    bad_addr_d  = bad_addr_q;
    dm.dm_ce    = 1'b0;
    dm.dm_we    = 1'b0;
    dm.dm_addr  = '0;
    dm.dm_wdata = '0;
    load_data   = '0;
    stall_req   = 1'b0;
    addr_err    = 1'b0;
    // Outputs are held at zero while reset is asserted.
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (!flush) begin
            if (mis) begin
              addr_err   = 1'b1;
              bad_addr_d = mem_addr;
            end else begin
              unique case (1'b1)
                is_ld: begin
                  dm.dm_ce   = 1'b1;
                  dm.dm_addr = waddr;
                  load_data  = ld_val;
                end
                is_sw: begin
                  dm.dm_ce    = 1'b1;
                  dm.dm_we    = 1'b1;
                  dm.dm_addr  = waddr;
                  dm.dm_wdata = mem_sdata;
                end
                is_sub: begin
                  dm.dm_ce   = 1'b1;
                  dm.dm_addr = waddr;
                  stall_req  = 1'b1;
                  rmw_addr_d = waddr;
                  rmw_word_d = merged;
                  state_d    = RMW;
                end
                default: ;
              endcase
            end
          end
        end
        RMW: begin
          state_d = IDLE;
          if (!flush) begin
            dm.dm_ce    = 1'b1;
            dm.dm_we    = 1'b1;
            dm.dm_addr  = rmw_addr_q;
            dm.dm_wdata = rmw_word_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rmw_addr_q <= '0;
      rmw_word_q <= '0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_word_q <= rmw_word_d;
      bad_addr_q <= bad_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu against a word-array reference model.
// A small RAM model sits on the data memory bus.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_sdata;
  logic        flush;
  logic [31:0] load_data, bad_addr;
  logic        stall_req, addr_err;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_bad;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          stall_cnt = 0;

  mem_lsu_if #(.DATA_W(32)) dm ();

  mem_lsu #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .flush     (flush),
    .dm        (dm.master),
    .load_data (load_data),
    .stall_req (stall_req),
    .addr_err  (addr_err),
    .bad_addr  (bad_addr)
  );

  always #5 clk = ~clk;

  assign dm.dm_rdata = mem[dm.dm_addr[5:2]];

  always @(posedge clk) begin
    if (dm.dm_ce && dm.dm_we) mem[dm.dm_addr[5:2]] <= dm.dm_wdata;
    if (stall_req) stall_cnt <= stall_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_ref(input logic [3:0] op,
                                         input logic [31:0] w,
                                         input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (3 - a[1:0]))) & 32'hFF;
    h = (w >> (16 * (1 - a[1]))) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 128) ? b - 32'd256 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32768) ? h - 32'd65536 : h;
      4'd4:    return h;
      4'd5:    return w;
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input bit fl,
                        input bit rmw_fl);
    int          idx;
    bit          none, mis, sub;
    logic [31:0] w, mask, nw;
    int          sh;
    idx  = int'(a[5:2]);
    none = (op == 0) || (op > 8);
    mis  = ((op == 3 || op == 4 || op == 7) && a[0])
        || ((op == 5 || op == 8) && a[1:0] != 0);
    sub  = (op == 6 || op == 7);
    @(negedge clk);
    mem_op = op; mem_addr = a; mem_sdata = sd; flush = fl;
    #2;
    w = ref_mem[idx];
    if (fl || none) begin
      chk("idle_ce", {31'd0, dm.dm_ce}, 32'd0);
      chk("idle_err", {31'd0, addr_err}, 32'd0);
      chk("idle_ld", load_data, 32'd0);
    end else if (mis) begin
      chk("mis_err", {31'd0, addr_err}, 32'd1);
      chk("mis_ce", {31'd0, dm.dm_ce}, 32'd0);
      chk("mis_stall", {31'd0, stall_req}, 32'd0);
      exp_bad = a;
    end else if (op <= 5) begin
      chk("ld_ce_we", {30'd0, dm.dm_ce, dm.dm_we}, 32'd2);
      chk("ld_addr", dm.dm_addr, a & ~32'd3);
      chk("ld_data", load_data, ld_ref(op, w, a));
    end else if (!sub) begin
      chk("sw_ce_we", {30'd0, dm.dm_ce, dm.dm_we}, 32'd3);
      chk("sw_stall", {31'd0, stall_req}, 32'd0);
      chk("sw_addr", dm.dm_addr, a & ~32'd3);
      chk("sw_wdata", dm.dm_wdata, sd);
      ref_mem[idx] = sd;
    end else begin
      chk("rd_ce_we", {30'd0, dm.dm_ce, dm.dm_we}, 32'd2);
      chk("rd_stall", {31'd0, stall_req}, 32'd1);
      chk("rd_addr", dm.dm_addr, a & ~32'd3);
      if (op == 6) begin
        sh = 8 * (3 - int'(a[1:0]));
        mask = 32'hFF << sh;
      end else begin
        sh = 16 * (1 - int'(a[1]));
        mask = 32'hFFFF << sh;
      end
      nw = (w & ~mask) | ((sd << sh) & mask);
      @(negedge clk);
      flush = rmw_fl;
      #2;
      chk("rmw_stall", {31'd0, stall_req}, 32'd0);
      chk("rmw_ld", load_data, 32'd0);
      if (rmw_fl) begin
        chk("rmw_fl_cewe", {30'd0, dm.dm_ce, dm.dm_we}, 32'd0);
      end else begin
        chk("rmw_ce_we", {30'd0, dm.dm_ce, dm.dm_we}, 32'd3);
        chk("rmw_addr", dm.dm_addr, a & ~32'd3);
        chk("rmw_wdata", dm.dm_wdata, nw);
        ref_mem[idx] = nw;
      end
    end
    @(posedge clk);
    #1;
    chk("bad_addr", bad_addr, exp_bad);
    chk("mem_word", mem[idx], ref_mem[idx]);
    flush = 1'b0;
    mem_op = 4'd0;
  endtask

  initial begin
    int s0;
    rst = 1'b0; flush = 1'b0;
    mem_op = 4'd5; mem_addr = 32'h10; mem_sdata = 32'h0;
    exp_bad = 32'd0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[4] = 32'h11223344;
    ref_mem[4] = 32'h11223344;
    #2;
    chk("rst_ce", {31'd0, dm.dm_ce}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_bad", bad_addr, 32'd0);
    @(negedge clk);
    mem_op = 4'd0;
    @(negedge clk);
    rst = 1'b1;

    run_op(4'd1, 32'h13, 0, 0, 0);
    run_op(4'd5, 32'h10, 0, 0, 0);
    run_op(4'd8, 32'h10, 32'h81223344, 0, 0);
    run_op(4'd1, 32'h10, 0, 0, 0);
    run_op(4'd2, 32'h10, 0, 0, 0);
    run_op(4'd3, 32'h12, 0, 0, 0);
    run_op(4'd4, 32'h10, 0, 0, 0);
    run_op(4'd8, 32'h10, 32'h11223344, 0, 0);
    run_op(4'd6, 32'h11, 32'h000000AA, 0, 0);
    chk("plan_sb", mem[4], 32'h11AA3344);
    run_op(4'd5, 32'h10, 0, 0, 0);
    run_op(4'd8, 32'h10, 32'h11223344, 0, 0);
    s0 = stall_cnt;
    run_op(4'd7, 32'h12, 32'h0000BEEF, 0, 0);
    run_op(4'd6, 32'h10, 32'h00000055, 0, 0);
    chk("plan_b2b", mem[4], 32'h5522BEEF);
    chk("plan_stalls", stall_cnt - s0, 32'd2);
    run_op(4'd5, 32'h22, 0, 0, 0);
    run_op(4'd7, 32'h13, 32'h1234, 0, 0);
    chk("plan_bad", bad_addr, 32'h13);
    run_op(4'd6, 32'h14, 32'h77, 0, 1);
    run_op(4'd8, 32'h04, 32'hDEADBEEF, 0, 0);
    run_op(4'd5, 32'h04, 0, 0, 0);
    chk("plan_sw", mem[1], 32'hDEADBEEF);

    // reset asserted in the middle of a read-modify-write
    @(negedge clk);
    mem_op = 4'd6; mem_addr = 32'h08; mem_sdata = 32'hCC; flush = 1'b0;
    #2;
    chk("rr_stall", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rr_cewe", {30'd0, dm.dm_ce, dm.dm_we}, 32'd0);
    chk("rr_stall0", {31'd0, stall_req}, 32'd0);
    chk("rr_bad", bad_addr, 32'd0);
    exp_bad = 32'd0;
    @(posedge clk);
    #1;
    chk("rr_mem", mem[2], ref_mem[2]);
    @(negedge clk);
    mem_op = 4'd0;
    rst = 1'b1;

    for (int k = 0; k < 300; k++) begin
      run_op(4'($urandom % 16), $urandom % 64, $urandom,
             ($urandom % 10) == 0, ($urandom % 8) == 0);
    end
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
